// File: rtl/drive_mode_ctrl.sv
// drive_mode_ctrl: top-level operating-mode controller for the robot.
// IR buttons select IDLE / CAM / IR. CAM mode runs a SEARCH/FOLLOW/LOST
// tracker with a lost-target timeout; IR mode drives manual commands with
// a hold timeout and a saturating manual speed. All outputs are registered.
module drive_mode_ctrl #(
    parameter int         SPEED_W      = 2,
    parameter int         LOST_TIMEOUT = 25000000,
    parameter int         IR_HOLD      = 5000000,
    parameter logic [7:0] BTN_CAM      = 8'h0F,
    parameter logic [7:0] BTN_IR       = 8'h13,
    parameter logic [7:0] BTN_IDLE     = 8'h10,
    parameter logic [7:0] BTN_FWD      = 8'h18,
    parameter logic [7:0] BTN_LEFT     = 8'h14,
    parameter logic [7:0] BTN_RIGHT    = 8'h16,
    parameter logic [7:0] BTN_STOP     = 8'h1C,
    parameter logic [7:0] BTN_FASTER   = 8'h1A,
    parameter logic [7:0] BTN_SLOWER   = 8'h1B
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               ir_valid,
    input  logic [7:0]         ir_code,
    input  logic               cam_valid,
    input  logic               cam_detected,
    input  logic [2:0]         cam_direction,
    input  logic [SPEED_W-1:0] cam_speed,
    output logic [1:0]         mode,
    output logic [1:0]         cam_state,
    output logic [2:0]         drive_cmd,
    output logic [SPEED_W-1:0] drive_speed,
    output logic               mode_change
);

    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_CAM  = 2'b01,
        MODE_IR   = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        CS_SEARCH = 2'b00,
        CS_FOLLOW = 2'b01,
        CS_LOST   = 2'b10,
        CS_PAUSE  = 2'b11
    } cam_state_t;

    typedef enum logic [2:0] {
        CMD_STOP  = 3'b000,
        CMD_LEFT  = 3'b001,
        CMD_RIGHT = 3'b010,
        CMD_FWD   = 3'b011
    } cmd_t;

    localparam int LOST_W = $clog2(LOST_TIMEOUT);
    localparam int HOLD_W = $clog2(IR_HOLD);
    localparam logic [LOST_W-1:0]  LOST_LAST = LOST_W'(LOST_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(IR_HOLD - 1);
    localparam logic [SPEED_W-1:0] SPEED_MAX = '1;

    mode_t              r_mode, w_mode_next;
    cam_state_t         r_cam_state, w_cam_state_next;
    cmd_t               r_drive_cmd, w_drive_cmd_next;
    logic [SPEED_W-1:0] r_drive_speed, w_drive_speed_next;
    logic [SPEED_W-1:0] r_manual_speed, w_manual_speed_next;
    logic               r_mode_change, w_mode_change_next;
    logic [LOST_W-1:0]  r_lost_cnt, w_lost_cnt_next;
    logic [HOLD_W-1:0]  r_hold_cnt, w_hold_cnt_next;

    cmd_t               w_dir_cmd;
    logic [SPEED_W-1:0] w_dir_speed;
    cmd_t               w_motion_cmd;
    logic               w_is_motion;
    logic               w_is_stop;
    logic               w_is_faster;
    logic               w_is_slower;

    // Camera direction to drive command; only a centred target uses cam_speed.
    always_comb begin
        w_dir_cmd   = CMD_STOP;
        w_dir_speed = '0;
        case (cam_direction)
            3'b001:  w_dir_cmd = CMD_LEFT;
            3'b010:  w_dir_cmd = CMD_RIGHT;
            3'b011: begin
                w_dir_cmd   = CMD_FWD;
                w_dir_speed = cam_speed;
            end
            default: w_dir_cmd = CMD_STOP;
        endcase
    end

    // Classify the current IR button for manual driving.
    always_comb begin
        w_motion_cmd = CMD_STOP;
        if (ir_code == BTN_FWD)
            w_motion_cmd = CMD_FWD;
        else if (ir_code == BTN_LEFT)
            w_motion_cmd = CMD_LEFT;
        else if (ir_code == BTN_RIGHT)
            w_motion_cmd = CMD_RIGHT;
        w_is_motion = ir_valid && (ir_code == BTN_FWD || ir_code == BTN_LEFT || ir_code == BTN_RIGHT);
        w_is_stop   = ir_valid && (ir_code == BTN_STOP);
        w_is_faster = ir_valid && (ir_code == BTN_FASTER);
        w_is_slower = ir_valid && (ir_code == BTN_SLOWER);
    end

    // Next mode, tracker state, drive command and counters.
    always_comb begin
        w_mode_next         = r_mode;
        w_cam_state_next    = r_cam_state;
        w_drive_cmd_next    = r_drive_cmd;
        w_drive_speed_next  = r_drive_speed;
        w_manual_speed_next = r_manual_speed;
        w_lost_cnt_next     = '0;
        w_hold_cnt_next     = '0;

        if (ir_valid) begin
            if (ir_code == BTN_CAM)
                w_mode_next = MODE_CAM;
            else if (ir_code == BTN_IR)
                w_mode_next = MODE_IR;
            else if (ir_code == BTN_IDLE)
                w_mode_next = MODE_IDLE;
        end
        w_mode_change_next = (w_mode_next != r_mode);

        case (w_mode_next)
            MODE_CAM: begin
                if (r_mode != MODE_CAM) begin
                    // Fresh entry always starts searching.
                    w_cam_state_next   = CS_SEARCH;
                    w_drive_cmd_next   = CMD_RIGHT;
                    w_drive_speed_next = '0;
                end else if (cam_valid && cam_detected) begin
                    // Detection wins over a coincident lost timeout.
                    w_cam_state_next   = CS_FOLLOW;
                    w_drive_cmd_next   = w_dir_cmd;
                    w_drive_speed_next = w_dir_speed;
                end else begin
                    case (r_cam_state)
                        CS_FOLLOW: begin
                            if (cam_valid) begin
                                w_cam_state_next   = CS_LOST;
                                w_drive_cmd_next   = CMD_STOP;
                                w_drive_speed_next = '0;
                            end
                        end
                        CS_LOST: begin
                            w_drive_cmd_next   = CMD_STOP;
                            w_drive_speed_next = '0;
                            if (r_lost_cnt == LOST_LAST) begin
                                w_cam_state_next = CS_SEARCH;
                                w_drive_cmd_next = CMD_RIGHT;
                            end else begin
                                w_lost_cnt_next = r_lost_cnt + LOST_W'(1);
                            end
                        end
                        default: begin
                            w_cam_state_next   = CS_SEARCH;
                            w_drive_cmd_next   = CMD_RIGHT;
                            w_drive_speed_next = '0;
                        end
                    endcase
                end
            end
            MODE_IR: begin
                w_cam_state_next = CS_PAUSE;
                if (r_mode != MODE_IR) begin
                    w_drive_cmd_next   = CMD_STOP;
                    w_drive_speed_next = '0;
                end else if (w_is_motion) begin
                    w_drive_cmd_next   = w_motion_cmd;
                    w_drive_speed_next = r_manual_speed;
                end else if (w_is_stop) begin
                    w_drive_cmd_next   = CMD_STOP;
                    w_drive_speed_next = '0;
                end else begin
                    if (w_is_faster && r_manual_speed != SPEED_MAX)
                        w_manual_speed_next = r_manual_speed + SPEED_W'(1);
                    else if (w_is_slower && r_manual_speed != '0)
                        w_manual_speed_next = r_manual_speed - SPEED_W'(1);
                    // A moving command expires unless a motion code repeats.
                    if (r_drive_cmd != CMD_STOP) begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            w_drive_cmd_next   = CMD_STOP;
                            w_drive_speed_next = '0;
                        end else begin
                            w_hold_cnt_next    = r_hold_cnt + HOLD_W'(1);
                            w_drive_speed_next = w_manual_speed_next;
                        end
                    end
                end
            end
            default: begin
                w_cam_state_next   = CS_PAUSE;
                w_drive_cmd_next   = CMD_STOP;
                w_drive_speed_next = '0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_mode         <= MODE_IDLE;
            r_cam_state    <= CS_PAUSE;
            r_drive_cmd    <= CMD_STOP;
            r_drive_speed  <= '0;
            r_manual_speed <= '0;
            r_mode_change  <= 1'b0;
            r_lost_cnt     <= '0;
            r_hold_cnt     <= '0;
        end else begin
            r_mode         <= w_mode_next;
            r_cam_state    <= w_cam_state_next;
            r_drive_cmd    <= w_drive_cmd_next;
            r_drive_speed  <= w_drive_speed_next;
            r_manual_speed <= w_manual_speed_next;
            r_mode_change  <= w_mode_change_next;
            r_lost_cnt     <= w_lost_cnt_next;
            r_hold_cnt     <= w_hold_cnt_next;
        end
    end

    assign mode        = r_mode;
    assign cam_state   = r_cam_state;
    assign drive_cmd   = r_drive_cmd;
    assign drive_speed = r_drive_speed;
    assign mode_change = r_mode_change;

endmodule

// File: tb/tb_drive_mode_ctrl.sv
// tb_drive_mode_ctrl: directed test-plan sequence plus randomized strobes,
// checked each cycle against a timestamp-based behavioural model, with
// literal expectations pinning the key scenarios.
module tb_drive_mode_ctrl;
    localparam int SPEED_W      = 2;
    localparam int LOST_TIMEOUT = 8;
    localparam int IR_HOLD      = 10;
    localparam int SMAX         = (1 << SPEED_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               ir_valid;
    logic [7:0]         ir_code;
    logic               cam_valid;
    logic               cam_detected;
    logic [2:0]         cam_direction;
    logic [SPEED_W-1:0] cam_speed;
    logic [1:0]         mode;
    logic [1:0]         cam_state;
    logic [2:0]         drive_cmd;
    logic [SPEED_W-1:0] drive_speed;
    logic               mode_change;

    always #5 clk = ~clk;

    drive_mode_ctrl #(
        .SPEED_W(SPEED_W),
        .LOST_TIMEOUT(LOST_TIMEOUT),
        .IR_HOLD(IR_HOLD)
    ) dut (
        .CLOCK_50(clk),
        .reset(rst),
        .ir_valid(ir_valid),
        .ir_code(ir_code),
        .cam_valid(cam_valid),
        .cam_detected(cam_detected),
        .cam_direction(cam_direction),
        .cam_speed(cam_speed),
        .mode(mode),
        .cam_state(cam_state),
        .drive_cmd(drive_cmd),
        .drive_speed(drive_speed),
        .mode_change(mode_change)
    );

    int total = 0;
    int bad   = 0;

    // Model: modes 0 IDLE 1 CAM 2 IR; track 0 SEARCH 1 FOLLOW 2 LOST 3 PAUSE
    int     m_mode, m_track, m_cmd, m_speed, m_manual, m_pulse;
    longint cyc, lost_since, last_motion;
    int     dir_cmd_tab[8] = '{0, 1, 2, 3, 0, 0, 0, 0};
    logic [7:0] code_tab[10] = '{8'h0F, 8'h13, 8'h10, 8'h18, 8'h14, 8'h16,
                                 8'h1C, 8'h1A, 8'h1B, 8'h55};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input int em, input int ecs, input int ecmd,
                              input int espd, input int emc);
        check({tag, ".mode"}, 32'(mode), em);
        check({tag, ".cam_state"}, 32'(cam_state), ecs);
        check({tag, ".drive_cmd"}, 32'(drive_cmd), ecmd);
        check({tag, ".drive_speed"}, 32'(drive_speed), espd);
        check({tag, ".mode_change"}, 32'(mode_change), emc);
    endtask

    task automatic model_reset();
        m_mode = 0; m_track = 3; m_cmd = 0; m_speed = 0; m_manual = 0; m_pulse = 0;
        cyc = 0; lost_since = 0; last_motion = 0;
    endtask

    task automatic model_step(input logic iv, input logic [7:0] ic, input logic cv,
                              input logic cd, input logic [2:0] dir, input logic [1:0] sp);
        int old_mode;
        int new_mode;
        cyc++;
        old_mode = m_mode;
        new_mode = old_mode;
        if (iv) begin
            if (ic == 8'h0F) new_mode = 1;
            else if (ic == 8'h13) new_mode = 2;
            else if (ic == 8'h10) new_mode = 0;
        end
        m_pulse = (new_mode != old_mode) ? 1 : 0;
        m_mode  = new_mode;
        if (new_mode == 1) begin
            if (old_mode != 1) begin
                m_track = 0; m_cmd = 2; m_speed = 0;
            end else if (cv && cd) begin
                m_track = 1; m_cmd = dir_cmd_tab[dir]; m_speed = (dir == 3'd3) ? int'(sp) : 0;
            end else if (m_track == 1) begin
                if (cv) begin
                    m_track = 2; lost_since = cyc; m_cmd = 0; m_speed = 0;
                end
            end else if (m_track == 2) begin
                if (cyc - lost_since >= LOST_TIMEOUT) begin
                    m_track = 0; m_cmd = 2; m_speed = 0;
                end
            end
        end else if (new_mode == 2) begin
            m_track = 3;
            if (old_mode != 2) begin
                m_cmd = 0; m_speed = 0;
            end else if (iv && (ic == 8'h18 || ic == 8'h14 || ic == 8'h16)) begin
                m_cmd = (ic == 8'h18) ? 3 : (ic == 8'h14) ? 1 : 2;
                m_speed = m_manual;
                last_motion = cyc;
            end else if (iv && ic == 8'h1C) begin
                m_cmd = 0; m_speed = 0;
            end else begin
                if (iv && ic == 8'h1A && m_manual < SMAX) m_manual++;
                if (iv && ic == 8'h1B && m_manual > 0) m_manual--;
                if (m_cmd != 0) begin
                    if (cyc - last_motion >= IR_HOLD) begin
                        m_cmd = 0; m_speed = 0;
                    end else begin
                        m_speed = m_manual;
                    end
                end
            end
        end else begin
            m_track = 3; m_cmd = 0; m_speed = 0;
        end
    endtask

    task automatic compare_all();
        check("mode", 32'(mode), m_mode);
        check("cam_state", 32'(cam_state), m_track);
        check("drive_cmd", 32'(drive_cmd), m_cmd);
        check("drive_speed", 32'(drive_speed), m_speed);
        check("mode_change", 32'(mode_change), m_pulse);
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic step(input logic iv, input logic [7:0] ic, input logic cv,
                        input logic cd, input logic [2:0] dir, input logic [1:0] sp);
        ir_valid = iv; ir_code = ic; cam_valid = cv;
        cam_detected = cd; cam_direction = dir; cam_speed = sp;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(iv, ic, cv, cd, dir, sp);
        @(negedge clk);
        compare_all();
        if (iv || cv)
            $display("txn t=%0t ir=%0b/%02h cam=%0b det=%0b dir=%0d spd=%0d -> mode=%0d cs=%0d cmd=%0d speed=%0d mc=%0b",
                     $time, iv, ic, cv, cd, dir, sp, mode, cam_state, drive_cmd, drive_speed, mode_change);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 2'd0);
    endtask

    task automatic press(input logic [7:0] c);
        step(1'b1, c, 1'b0, 1'b0, 3'd0, 2'd0);
    endtask

    task automatic frame(input logic det, input logic [2:0] dir, input logic [1:0] sp);
        step(1'b0, 8'h00, 1'b1, det, dir, sp);
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        idle(2);
        expect_out("reset", 0, 3, 0, 0, 0);
        rst = 1'b0;

        press(8'h0F);          expect_out("enter_cam", 1, 0, 2, 0, 1);
        idle(1);               expect_out("cam_settle", 1, 0, 2, 0, 0);
        press(8'h0F);          expect_out("cam_repeat", 1, 0, 2, 0, 0);
        frame(1, 3'd3, 2'd2);  expect_out("follow_fwd", 1, 1, 3, 2, 0);
        frame(0, 3'd0, 2'd0);  expect_out("to_lost", 1, 2, 0, 0, 0);
        idle(7);               expect_out("lost_7", 1, 2, 0, 0, 0);
        idle(1);               expect_out("timeout_8", 1, 0, 2, 0, 0);
        frame(1, 3'd3, 2'd1);  expect_out("follow_again", 1, 1, 3, 1, 0);
        frame(0, 3'd0, 2'd0);
        idle(4);
        frame(1, 3'd1, 2'd3);  expect_out("redetect_left", 1, 1, 1, 0, 0);
        frame(0, 3'd0, 2'd0);
        idle(7);
        frame(1, 3'd2, 2'd0);  expect_out("timeout_and_detect", 1, 1, 2, 0, 0);
        idle(3);               expect_out("follow_hold", 1, 1, 2, 0, 0);
        frame(1, 3'd5, 2'd2);  expect_out("bad_direction", 1, 1, 0, 0, 0);

        press(8'h13);          expect_out("enter_ir", 2, 3, 0, 0, 1);
        for (int i = 0; i < 5; i++) press(8'h1A);
        expect_out("faster_while_stopped", 2, 3, 0, 0, 0);
        press(8'h18);          expect_out("fwd_max", 2, 3, 3, 3, 0);
        idle(9);               expect_out("hold_9", 2, 3, 3, 3, 0);
        idle(1);               expect_out("hold_expire", 2, 3, 0, 0, 0);
        for (int i = 0; i < 5; i++) press(8'h1B);
        press(8'h14);          expect_out("left_min", 2, 3, 1, 0, 0);
        press(8'h1A);          expect_out("faster_live", 2, 3, 1, 1, 0);
        press(8'h1C);          expect_out("btn_stop", 2, 3, 0, 0, 0);
        press(8'h10);          expect_out("to_idle", 0, 3, 0, 0, 1);
        press(8'h13);
        press(8'h16);          expect_out("speed_persist", 2, 3, 2, 1, 0);

        press(8'h0F);
        step(1'b1, 8'h10, 1'b1, 1'b1, 3'd3, 2'd3);
        expect_out("idle_priority", 0, 3, 0, 0, 1);

        press(8'h0F);
        frame(1, 3'd3, 2'd3);  expect_out("pre_reset_follow", 1, 1, 3, 3, 0);
        #2 rst = 1'b1;
        #1 expect_out("async_reset", 0, 3, 0, 0, 0);
        model_reset();
        idle(2);
        rst = 1'b0;

        for (int i = 0; i < 2500; i++) begin
            logic       iv;
            logic [7:0] ic;
            logic       cv;
            iv = ($urandom_range(0, 7) == 0);
            ic = code_tab[$urandom_range(0, 9)];
            cv = ($urandom_range(0, 2) == 0);
            step(iv, ic, cv, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
